writeback_stage: RTL and testbench

Writeback stage directly upstream of the core register file's write port. It merges single-cycle ALU results and variable-latency load results from the LSU into one registered write per cycle. It drives `reg_wr_en`/`rd_addr`/`wr_data` of the register file. It also keeps a pending-load scoreboard that decode uses to stall on RAW hazards against outstanding loads.

---
 rtl/writeback_if.sv | 48 ++++
 rtl/writeback_stage.sv | 195 +++++++++++++++++++
 tb/tb_writeback_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Writeback stage bus bundle: ALU result, load issue, LSU load-result
// handshake, register file write port and the pending-load scoreboard.
// The writeback stage sits on the slave side. The upstream pipeline,
// LSU and register file sit on the master side.
interface writeback_if;

   // ALU result path (no backpressure)
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;

   // Load issue from decode (scoreboard set)
   logic        ld_issue_i;
   logic [4:0]  ld_issue_rd_i;

   // LSU load-result handshake
   logic        ld_valid_i;
   logic        ld_ready_o;
   logic [4:0]  ld_rd_i;
   logic [31:0] ld_data_i;

   // Register file write port
   logic        reg_wr_en_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] wr_data_o;

   // Outstanding-load scoreboard towards decode
   logic [31:0] pending_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  ld_issue_i, ld_issue_rd_i,
      input  ld_valid_i, ld_rd_i, ld_data_i,
      output ld_ready_o,
      output reg_wr_en_o, rd_addr_o, wr_data_o,
      output pending_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output ld_issue_i, ld_issue_rd_i,
      output ld_valid_i, ld_rd_i, ld_data_i,
      input  ld_ready_o,
      input  reg_wr_en_o, rd_addr_o, wr_data_o,
      input  pending_o
   );

endinterface : writeback_if

// File: rtl/writeback_stage.sv
// Writeback stage in front of the register file write port.
// It merges single-cycle ALU results and variable-latency LSU load results
// into one registered write per cycle. ALU writes have absolute priority.
// Loads that cannot be written immediately wait in a small in-order FIFO.
// A pending-load scoreboard lets decode stall on RAW hazards against
// loads that are still in flight.
module writeback_stage #(
   parameter int unsigned LD_FIFO_DEPTH = 2   // legal range 1..8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   writeback_if.slave wb
);

   // ---------------------------------------------------------------------
   // Sizing
   // ---------------------------------------------------------------------
   localparam int unsigned CNT_W = $clog2(LD_FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LD_FIFO_DEPTH - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   // Load-result FIFO storage: {rd, data} per entry
   logic [4:0]       fifo_rd_q   [LD_FIFO_DEPTH];
   logic [31:0]      fifo_data_q [LD_FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // Output register feeding the register file
   logic             wr_en_q,  wr_en_d;
   logic             src_ld_q, src_ld_d;   // current write came from a load
   logic [4:0]       rd_q,     rd_d;
   logic [31:0]      data_q,   data_d;

   // Pending-load scoreboard
   logic [31:0]      pending_q, pending_d;

   // ---------------------------------------------------------------------
   // Datapath control
   // ---------------------------------------------------------------------
   logic alu_wr;      // ALU write to a real register this cycle
   logic ld_ready;    // FIFO has room; depends on registered state only
   logic ld_xfer;     // LSU handshake completes this cycle
   logic ld_keep;     // transferred load targets a real register
   logic fifo_empty;
   logic pop;         // FIFO head goes to the output register
   logic bypass;      // transferred load goes straight to the output register
   logic push;        // transferred load is buffered

   assign alu_wr     = wb.alu_valid_i && (wb.alu_rd_i != 5'd0);
   assign ld_ready   = (count_q != FULL_CNT);
   assign ld_xfer    = wb.ld_valid_i && ld_ready;
   assign ld_keep    = ld_xfer && (wb.ld_rd_i != 5'd0);
   assign fifo_empty = (count_q == '0);

   // Priority: ALU write, then FIFO head, then bypass of the new load.
   // The bypass only applies when the FIFO is empty, which keeps loads in
   // acceptance order. A load to x0 is consumed but neither pushed nor
   // written.
   assign pop    = !alu_wr && !fifo_empty;
   assign bypass = !alu_wr &&  fifo_empty && ld_keep;
   assign push   = ld_keep && !bypass;

   // ---------------------------------------------------------------------
   // Output register next-state: pick the single write for next cycle
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the priority chain so no
      //       path leaves it unassigned, which would infer a latch.
      wr_en_d  = 1'b0;
      src_ld_d = 1'b0;
      rd_d     = rd_q;
      data_d   = data_q;

      if (alu_wr) begin
         wr_en_d = 1'b1;
         rd_d    = wb.alu_rd_i;
         data_d  = wb.alu_data_i;
      end else if (!fifo_empty) begin
         wr_en_d  = 1'b1;
         src_ld_d = 1'b1;
         rd_d     = fifo_rd_q[rd_ptr_q];
         data_d   = fifo_data_q[rd_ptr_q];
      end else if (ld_keep) begin
         wr_en_d  = 1'b1;
         src_ld_d = 1'b1;
         rd_d     = wb.ld_rd_i;
         data_d   = wb.ld_data_i;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO pointer and occupancy next-state
   // ---------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end

      // A simultaneous push and pop leaves the occupancy unchanged
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------
   // Scoreboard next-state: set on issue, clear after a load write lands
   // ---------------------------------------------------------------------
   always_comb begin
      logic [31:0] set_mask;
      logic [31:0] clr_mask;

      set_mask = '0;
      clr_mask = '0;

      if (wb.ld_issue_i && (wb.ld_issue_rd_i != 5'd0)) begin
         set_mask[wb.ld_issue_rd_i] = 1'b1;
      end

      // The clear uses the registered write, so the bit drops exactly when
      // the register file holds the loaded value. ALU writes never clear a
      // bit: decode stalls on WAW against a pending load.
      if (wr_en_q && src_ld_q) begin
         clr_mask[rd_q] = 1'b1;
      end

      // Set wins over clear for the same register. x0 is never pending.
      pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'h0000_0001;
   end

   // ---------------------------------------------------------------------
   // Control and output state registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every
      //       register samples the pre-edge values of the others.
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         src_ld_q  <= 1'b0;
         rd_q      <= 5'd0;
         data_q    <= 32'd0;
         pending_q <= 32'd0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         src_ld_q  <= src_ld_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage write
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: the storage array has no reset. The occupancy count already
      //       marks every entry invalid after reset, so a stale entry is
      //       never read.
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= wb.ld_rd_i;
         fifo_data_q[wr_ptr_q] <= wb.ld_data_i;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign wb.ld_ready_o  = ld_ready;
   assign wb.reg_wr_en_o = wr_en_q;
   assign wb.rd_addr_o   = rd_q;
   assign wb.wr_data_o   = data_q;
   assign wb.pending_o   = pending_q;

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (LD_FIFO_DEPTH = 2).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at the same point, so each check sees the state captured at the
// preceding edge.
module tb_writeback_stage;

   logic clk_i = 1'b0;
   logic rst_ni;

   always #5 clk_i = ~clk_i;

   writeback_if wb_if ();

   writeback_stage #(.LD_FIFO_DEPTH(2)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wb     (wb_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic idle();
      wb_if.alu_valid_i   = 1'b0;
      wb_if.alu_rd_i      = 5'd0;
      wb_if.alu_data_i    = 32'd0;
      wb_if.ld_issue_i    = 1'b0;
      wb_if.ld_issue_rd_i = 5'd0;
      wb_if.ld_valid_i    = 1'b0;
      wb_if.ld_rd_i       = 5'd0;
      wb_if.ld_data_i     = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
      wb_if.alu_valid_i = 1'b1;
      wb_if.alu_rd_i    = rd;
      wb_if.alu_data_i  = data;
   endtask

   task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
      wb_if.ld_valid_i = 1'b1;
      wb_if.ld_rd_i    = rd;
      wb_if.ld_data_i  = data;
   endtask

   task automatic issue(input logic [4:0] rd);
      wb_if.ld_issue_i    = 1'b1;
      wb_if.ld_issue_rd_i = rd;
      tick();
      wb_if.ld_issue_i    = 1'b0;
   endtask

   // Reset state, asserted from time 0
   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      #2;
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== 38'd0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%0b rd=%0d data=%h, expected all 0",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      checks++;
      if (wb_if.pending_o !== 32'd0 || wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got pending=%h ready=%0b, expected 0 and 1",
                  wb_if.pending_o, wb_if.ld_ready_o);
      end
      tick();
      rst_ni = 1'b1;
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got en=%0b, expected 0", wb_if.reg_wr_en_o);
      end
   endtask

   // ALU write latency, then an ALU write to x0 that must be dropped
   task automatic test_alu();
      drive_alu(5'd5, 32'hDEAD_BEEF);
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL alu_write: got en=%0b rd=%0d data=%h, expected en=1 rd=5 data=deadbeef",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_single_cycle: got en=%0b, expected 0", wb_if.reg_wr_en_o);
      end
      drive_alu(5'd0, 32'hDEAD_BEEF);
      tick();
      idle();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_x0_dropped: got en=%0b, expected 0", wb_if.reg_wr_en_o);
      end
   endtask

   // ALU and load in the same cycle: ALU first, load next, then clear
   task automatic test_collision();
      issue(5'd7);
      checks++;
      if (wb_if.pending_o !== 32'h0000_0080) begin
         errors++;
         $display("FAIL collision_pending_set: got %h, expected 00000080", wb_if.pending_o);
      end
      drive_alu(5'd3, 32'h0000_3333);
      drive_ld(5'd7, 32'h0000_0011);
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd3, 32'h0000_3333}) begin
         errors++;
         $display("FAIL collision_alu_first: got en=%0b rd=%0d data=%h, expected en=1 rd=3 data=00003333",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd7, 32'h0000_0011}) begin
         errors++;
         $display("FAIL collision_load_second: got en=%0b rd=%0d data=%h, expected en=1 rd=7 data=00000011",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      checks++;
      if (wb_if.pending_o !== 32'h0000_0080) begin
         errors++;
         $display("FAIL collision_pending_held: got %h, expected 00000080", wb_if.pending_o);
      end
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0 || wb_if.pending_o !== 32'd0) begin
         errors++;
         $display("FAIL collision_pending_clear: got en=%0b pending=%h, expected 0 and 00000000",
                  wb_if.reg_wr_en_o, wb_if.pending_o);
      end
   endtask

   // FIFO fills behind a stream of ALU writes, then drains in order
   task automatic test_full();
      issue(5'd1);
      issue(5'd2);
      issue(5'd3);
      // Cycle A: FIFO empty but ALU wins -> load 1 is pushed
      drive_alu(5'd10, 32'd100);
      drive_ld(5'd1, 32'h0000_0101);
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o} !== {1'b1, 5'd10} || wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL full_alu0: got en=%0b rd=%0d ready=%0b, expected en=1 rd=10 ready=1",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.ld_ready_o);
      end
      // Cycle B: load 2 pushed, FIFO now full
      drive_alu(5'd11, 32'd101);
      drive_ld(5'd2, 32'h0000_0202);
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o} !== {1'b1, 5'd11} || wb_if.ld_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full_ready_low: got en=%0b rd=%0d ready=%0b, expected en=1 rd=11 ready=0",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.ld_ready_o);
      end
      // Cycles C and D: load 3 held by the LSU while ALU keeps winning
      drive_alu(5'd12, 32'd102);
      drive_ld(5'd3, 32'h0000_0303);
      tick();
      drive_alu(5'd13, 32'd103);
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd13, 32'd103}
          || wb_if.ld_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: got en=%0b rd=%0d data=%h ready=%0b, expected en=1 rd=13 data=00000067 ready=0",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o, wb_if.ld_ready_o);
      end
      // Cycle E: ALU stops; pop x1, ready rises next cycle
      wb_if.alu_valid_i = 1'b0;
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd1, 32'h0000_0101}
          || wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL full_drain_x1: got en=%0b rd=%0d data=%h ready=%0b, expected en=1 rd=1 data=00000101 ready=1",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o, wb_if.ld_ready_o);
      end
      // Cycle F: load 3 transfers (pushed) while x2 pops
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd2, 32'h0000_0202}) begin
         errors++;
         $display("FAIL full_drain_x2: got en=%0b rd=%0d data=%h, expected en=1 rd=2 data=00000202",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd3, 32'h0000_0303}
          || wb_if.pending_o !== 32'h0000_0008) begin
         errors++;
         $display("FAIL full_drain_x3: got en=%0b rd=%0d data=%h pending=%h, expected en=1 rd=3 data=00000303 pending=00000008",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o, wb_if.pending_o);
      end
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0 || wb_if.pending_o !== 32'd0) begin
         errors++;
         $display("FAIL full_drained: got en=%0b pending=%h, expected 0 and 00000000",
                  wb_if.reg_wr_en_o, wb_if.pending_o);
      end
   endtask

   // Scoreboard set, set-wins-over-clear, and a plain clear
   task automatic test_scoreboard();
      issue(5'd9);
      checks++;
      if (wb_if.pending_o !== 32'h0000_0200) begin
         errors++;
         $display("FAIL sb_set: got %h, expected 00000200", wb_if.pending_o);
      end
      tick();
      tick();
      drive_ld(5'd9, 32'h0000_0999);
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd9, 32'h0000_0999}) begin
         errors++;
         $display("FAIL sb_bypass_write: got en=%0b rd=%0d data=%h, expected en=1 rd=9 data=00000999",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      // Re-issue x9 in the same cycle the load write is on the port
      issue(5'd9);
      checks++;
      if (wb_if.pending_o !== 32'h0000_0200) begin
         errors++;
         $display("FAIL sb_set_wins: got %h, expected 00000200", wb_if.pending_o);
      end
      drive_ld(5'd9, 32'h0000_0AAA);
      tick();
      idle();
      tick();
      checks++;
      if (wb_if.pending_o !== 32'd0) begin
         errors++;
         $display("FAIL sb_clear: got %h, expected 00000000", wb_if.pending_o);
      end
   endtask

   // Load to x0: handshake completes, nothing written or buffered
   task automatic test_x0_load();
      issue(5'd0);
      checks++;
      if (wb_if.pending_o !== 32'd0) begin
         errors++;
         $display("FAIL x0_issue: got pending=%h, expected 00000000", wb_if.pending_o);
      end
      drive_ld(5'd0, 32'h0000_0055);
      checks++;
      if (wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL x0_ready: got %0b, expected 1", wb_if.ld_ready_o);
      end
      tick();
      // A following load must bypass, proving the x0 load was not buffered
      drive_ld(5'd4, 32'h0000_0444);
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0 || wb_if.pending_o !== 32'd0) begin
         errors++;
         $display("FAIL x0_no_write: got en=%0b pending=%h, expected 0 and 00000000",
                  wb_if.reg_wr_en_o, wb_if.pending_o);
      end
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd4, 32'h0000_0444}) begin
         errors++;
         $display("FAIL x0_then_bypass: got en=%0b rd=%0d data=%h, expected en=1 rd=4 data=00000444",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
   endtask

   // Consecutive ALU writes and consecutive bypassed loads
   task automatic test_back_to_back();
      drive_alu(5'd1, 32'h1111_0000);
      tick();
      drive_alu(5'd2, 32'h2222_0000);
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd1, 32'h1111_0000}) begin
         errors++;
         $display("FAIL b2b_alu1: got en=%0b rd=%0d data=%h, expected en=1 rd=1 data=11110000",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      idle();
      drive_ld(5'd5, 32'h0000_0055);
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd2, 32'h2222_0000}) begin
         errors++;
         $display("FAIL b2b_alu2: got en=%0b rd=%0d data=%h, expected en=1 rd=2 data=22220000",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      drive_ld(5'd6, 32'h0000_0066);
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd5, 32'h0000_0055}) begin
         errors++;
         $display("FAIL b2b_ld5: got en=%0b rd=%0d data=%h, expected en=1 rd=5 data=00000055",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== {1'b1, 5'd6, 32'h0000_0066}) begin
         errors++;
         $display("FAIL b2b_ld6: got en=%0b rd=%0d data=%h, expected en=1 rd=6 data=00000066",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o);
      end
      tick();
   endtask

   // Reset asserted with two loads buffered and a write on the port
   task automatic test_reset_mid();
      issue(5'd1);
      issue(5'd2);
      drive_alu(5'd20, 32'd20);
      drive_ld(5'd1, 32'h0000_0C01);
      tick();
      drive_alu(5'd21, 32'd21);
      drive_ld(5'd2, 32'h0000_0C02);
      tick();
      idle();
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o} !== {1'b1, 5'd21} || wb_if.ld_ready_o !== 1'b0
          || wb_if.pending_o !== 32'h0000_0006) begin
         errors++;
         $display("FAIL rstmid_setup: got en=%0b rd=%0d ready=%0b pending=%h, expected en=1 rd=21 ready=0 pending=00000006",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.ld_ready_o, wb_if.pending_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o} !== 38'd0
          || wb_if.pending_o !== 32'd0 || wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_async: got en=%0b rd=%0d data=%h pending=%h ready=%0b, expected all 0 and ready=1",
                  wb_if.reg_wr_en_o, wb_if.rd_addr_o, wb_if.wr_data_o, wb_if.pending_o, wb_if.ld_ready_o);
      end
      tick();
      #2;
      rst_ni = 1'b1;
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_release1: got en=%0b, expected 0", wb_if.reg_wr_en_o);
      end
      tick();
      checks++;
      if (wb_if.reg_wr_en_o !== 1'b0 || wb_if.ld_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_release2: got en=%0b ready=%0b, expected 0 and 1",
                  wb_if.reg_wr_en_o, wb_if.ld_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_collision();
      test_full();
      test_scoreboard();
      test_x0_load();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_writeback_stage
